nioslab2_stepper_ctrl: RTL
==========================

Name: nioslab2_stepper_ctrl

Overview:
Avalon-MM slave that sequences a 4-coil unipolar stepper motor: it generates the phase pattern on a 4-bit motor output at a programmable step rate, direction and step count. It replaces the bare software-driven motor PIO, so the NIOS only configures the block, starts it, and polls status or takes an interrupt. It sits on the same Avalon bus as the other PIOs and uses the same zero-wait-state register access.

Parameters:
PERIOD_W, 24, width of the step-period register in clocks
STEPS_W, 16, width of the step-count and remaining-steps counters
PERIOD_RST, 50000, reset value of PERIOD (1 ms per step at 50 MHz)

Ports:
clk  in  1  system clock; the block's only clock
reset_n  in  1  reset, synchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational from address
out_port  out  4  motor coil drive, bit0 = coil A … bit3 = coil D
irq  out  1  level interrupt, equals DONE & IE

Behaviour:
- Clocking and reset: one clock (clk); reset_n is synchronous and active-low.
- Reset values: out_port=0, irq=0, CTRL=0, PERIOD=PERIOD_RST, STEPS=0, phase index=0, state=IDLE, DONE=0.
- A register write occurs on a cycle where chipselect=1 and write_n=0. Reads have zero wait states; readdata is a pure function of address and the current state.
- Register map:
  - addr0 CTRL (R/W): bit0 EN, bit1 DIR (1 = index increments), bit2 HALF (half-step mode), bit5 IE. bit3 START and bit4 STOP are write-only pulses and always read as 0.
  - addr1 PERIOD (R/W): bits [PERIOD_W-1:0].
  - addr2 STEPS (R/W): bits [STEPS_W-1:0]; 0 means run continuously.
  - addr3 STATUS: bit0 BUSY (read-only), bit1 DONE (sticky, write 1 to clear), bits[31:16] remaining steps (read-only).
- Phase table, indexed by a 3-bit index: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Full-step mode uses the odd indices only and moves the index by ±2. Half-step mode moves the index by ±1. The index wraps modulo 8.
- out_port is 0 whenever EN=0. Otherwise it is table[index], including in IDLE, so the motor keeps holding torque.
- State machine:
  - IDLE → RUN on a write with START=1 and STOP=0, provided EN is 1 in that same write (the new CTRL value).
  - On that transition the block latches HALF and DIR into run copies, sets remaining = STEPS, and loads timer = max(PERIOD,2) − 1.
  - If the latched HALF=0, index[0] is forced to 1 on entry.
  - In RUN the timer decrements every cycle. When timer reaches 0:
    - index advances;
    - timer reloads from the current PERIOD value;
    - if remaining ≠ 0 it decrements; if it becomes 0, the next state is IDLE and DONE is set.
  - The first step occurs max(PERIOD,2) cycles after the START write.
  - RUN → IDLE also occurs on a STOP=1 write, or on EN being written to 0. This is an abort: DONE is not set and the index is held.
- Boundary rules:
  - START and STOP in the same write: STOP wins and the block stays or goes to IDLE.
  - START while in RUN: ignored.
  - A write to CTRL DIR/HALF during RUN updates the readable register only; the run uses its latched copies.
  - A write to PERIOD during RUN takes effect at the next reload.
  - A write to STEPS during RUN has no effect until the next START.
  - PERIOD values 0 and 1 are treated as 2.
  - The DONE-set event and a DONE-clear write in the same cycle: set wins.
  - reset_n low mid-run: the next clock edge restores all reset values.
- BUSY = (state == RUN).

Decomposition:
- Shared package holds: register address constants, CTRL/STATUS bit positions, the 8-entry phase table constant, and the state encoding (IDLE, RUN).
- One sub-module is natural: nioslab2_step_timer. It is the loadable PERIOD_W-bit down-counter and emits a one-cycle tick when it reaches 0.

Test Plan:
1. Reset, then read addr0–3 → 0, 50000, 0, 0; out_port=0; irq=0.
2. PERIOD=4, STEPS=3, then CTRL write EN|DIR|START (0x0B) → BUSY=1. Steps occur 4, 8 and 12 cycles after the write, with out_port 0011→0110→1100→1001. After the third step BUSY=0 and DONE=1; out_port holds 1001.
3. PERIOD=2, STEPS=0, CTRL write EN|HALF|START (DIR=0) from index 0 → out_port 0001→1001→1000→1100 every 2 cycles and continues indefinitely. A STOP write then gives BUSY=0 with DONE still 0.
4. With IE=1 and a completed run → irq=1. Writing STATUS=0x2 → DONE=0 and irq=0 on the next cycle.
5. CTRL write START|STOP|EN → stays IDLE. During a run, writing EN=0 → out_port=0000, BUSY=0, DONE=0.
6. PERIOD=1, STEPS=2, start the run → steps occur every 2 cycles. Assert reset_n=0 for one cycle mid-run → all reset values next cycle, including PERIOD=50000.

Source files
------------

// File: rtl/nioslab2_stepper_ctrl_pkg.sv
// Shared definitions for the stepper controller: register map, bit positions,
// coil phase table and state encoding.
package nioslab2_stepper_ctrl_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STEPS  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions (START/STOP are write-only pulses)
  localparam int CTRL_EN    = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_HALF  = 2;
  localparam int CTRL_START = 3;
  localparam int CTRL_STOP  = 4;
  localparam int CTRL_IE    = 5;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_REM_LSB = 16;

  // Coil pattern per 3-bit phase index; odd entries are the two-coil full steps.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Next phase index: +/-1 in half-step mode, +/-2 in full-step mode, wrapping mod 8.
  function automatic logic [2:0] next_index(input logic [2:0] idx,
                                            input logic dir,
                                            input logic half);
    logic [2:0] stride;
    stride = half ? 3'd1 : 3'd2;
    return dir ? (idx + stride) : (idx - stride);
  endfunction

endpackage

// File: rtl/nioslab2_stepper_ctrl_if.sv
// Avalon-MM register port of the stepper controller (zero wait states).
interface nioslab2_stepper_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nioslab2_step_timer.sv
// Loadable down-counter that paces motor steps; tick is high for the one
// running cycle in which the count sits at zero, and the counter reloads then.
module nioslab2_step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_reg;

  assign tick = run && (count_reg == '0);

  // Load on start, reload on tick, otherwise count down while running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= load_val;
    end else if (run) begin
      count_reg <= count_reg - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/nioslab2_stepper_ctrl.sv
// Avalon-MM stepper motor sequencer: drives a 4-coil unipolar motor at a
// programmable rate, direction and step count, with done status and interrupt.
module nioslab2_stepper_ctrl
  import nioslab2_stepper_ctrl_pkg::*;
#(
  parameter int PERIOD_W   = 24,
  parameter int STEPS_W    = 16,
  parameter int PERIOD_RST = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nioslab2_stepper_ctrl_if.slave  bus,
  output logic [3:0]              out_port,
  output logic                    irq
);

  state_t              state_reg;
  logic                en_reg, dir_reg, half_reg, ie_reg;
  logic                dir_run_reg, half_run_reg;
  logic                done_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [STEPS_W-1:0]  steps_reg;
  logic [STEPS_W-1:0]  remaining_reg;
  logic [2:0]          index_reg;

  logic                wr, wr_ctrl;
  logic [31:0]         wd;
  logic                start_req, abort_req;
  logic [PERIOD_W-1:0] reload_val;
  logic                step_tick;
  logic [31:0]         rdata;

  assign wr      = bus.chipselect && !bus.write_n;
  assign wr_ctrl = wr && (bus.address == ADDR_CTRL);
  assign wd      = bus.writedata;

  // STOP beats START, and START only counts if the same write enables the driver.
  assign start_req = wr_ctrl && wd[CTRL_START] && !wd[CTRL_STOP] && wd[CTRL_EN];
  assign abort_req = wr_ctrl && (wd[CTRL_STOP] || !wd[CTRL_EN]);

  // Periods of 0 and 1 behave as 2; the counter runs period-1 down to 0.
  assign reload_val = (period_reg < PERIOD_W'(2)) ? PERIOD_W'(1)
                                                  : period_reg - PERIOD_W'(1);

  nioslab2_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     ((state_reg == ST_IDLE) && start_req),
    .run      (state_reg == ST_RUN),
    .load_val (reload_val),
    .tick     (step_tick)
  );

  // Register file and run sequencer; a DONE set is written last so it beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      en_reg        <= 1'b0;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      ie_reg        <= 1'b0;
      dir_run_reg   <= 1'b0;
      half_run_reg  <= 1'b0;
      done_reg      <= 1'b0;
      period_reg    <= PERIOD_W'(PERIOD_RST);
      steps_reg     <= '0;
      remaining_reg <= '0;
      index_reg     <= 3'd0;
    end else begin
      if (wr_ctrl) begin
        en_reg   <= wd[CTRL_EN];
        dir_reg  <= wd[CTRL_DIR];
        half_reg <= wd[CTRL_HALF];
        ie_reg   <= wd[CTRL_IE];
      end
      if (wr && (bus.address == ADDR_PERIOD)) period_reg <= wd[PERIOD_W-1:0];
      if (wr && (bus.address == ADDR_STEPS))  steps_reg  <= wd[STEPS_W-1:0];
      if (wr && (bus.address == ADDR_STATUS) && wd[STAT_DONE]) done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start_req) begin
            state_reg     <= ST_RUN;
            dir_run_reg   <= wd[CTRL_DIR];
            half_run_reg  <= wd[CTRL_HALF];
            remaining_reg <= steps_reg;
            // Full-step runs must sit on an odd (two-coil) phase.
            if (!wd[CTRL_HALF]) index_reg[0] <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state_reg <= ST_IDLE;
          end else if (step_tick) begin
            index_reg <= next_index(index_reg, dir_run_reg, half_run_reg);
            if (remaining_reg != '0) begin
              remaining_reg <= remaining_reg - STEPS_W'(1);
              if (remaining_reg == STEPS_W'(1)) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rdata[CTRL_EN]   = en_reg;
        rdata[CTRL_DIR]  = dir_reg;
        rdata[CTRL_HALF] = half_reg;
        rdata[CTRL_IE]   = ie_reg;
      end
      ADDR_PERIOD: rdata[PERIOD_W-1:0] = period_reg;
      ADDR_STEPS:  rdata[STEPS_W-1:0]  = steps_reg;
      default: begin
        rdata[STAT_BUSY] = (state_reg == ST_RUN);
        rdata[STAT_DONE] = done_reg;
        rdata[STAT_REM_LSB +: STEPS_W] = remaining_reg;
      end
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = en_reg ? PHASE_TABLE[index_reg] : 4'b0000;
  assign irq          = done_reg && ie_reg;

endmodule
